// File: rtl/uci_pkg.sv
// Shared types and constants for the UCI "bestmove" line parser.
package uci_pkg;

  typedef enum logic [2:0] {
    ST_KW    = 3'd0,
    ST_GAP   = 3'd1,
    ST_MOVE  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_SKIP  = 3'd4
  } state_t;

  localparam logic [63:0] KEYWORD  = "bestmove";
  localparam logic [3:0]  KW_LEN   = 4'd8;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [2:0] PROMO_NONE = 3'd0;
  localparam logic [2:0] PROMO_N    = 3'd1;
  localparam logic [2:0] PROMO_B    = 3'd2;
  localparam logic [2:0] PROMO_R    = 3'd3;
  localparam logic [2:0] PROMO_Q    = 3'd4;

  // Keyword character at position idx (0 = 'b').
  function automatic logic [7:0] kw_char(input logic [2:0] idx);
    logic [63:0] shifted;
    shifted = KEYWORD << {idx, 3'b000};
    return shifted[63:56];
  endfunction

  function automatic logic [2:0] promo_code(input logic [7:0] ch);
    case (ch)
      8'h6E:   return PROMO_N;
      8'h62:   return PROMO_B;
      8'h72:   return PROMO_R;
      8'h71:   return PROMO_Q;
      default: return PROMO_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uci_square_decode.sv
// Converts an ASCII file/rank pair ("e","2") into a 6-bit square index
// rank*8+file, with a flag saying both characters were in range.
module uci_square_decode (
  input  logic [7:0] file_ch,
  input  logic [7:0] rank_ch,
  output logic [5:0] sq,
  output logic       ok
);

  // 'a'..'h' and '1'..'8' both end in low bits 001..000, so a 3-bit
  // decrement of the low bits yields 0..7 once the range is confirmed.
  assign ok = (file_ch >= 8'h61) && (file_ch <= 8'h68) &&
              (rank_ch >= 8'h31) && (rank_ch <= 8'h38);
  assign sq = {rank_ch[2:0] - 3'd1, file_ch[2:0] - 3'd1};

endmodule

// File: rtl/uci_move_parser.sv
// UCI engine-output parser: reports the move of each "bestmove" line.
// Build option: define UCI_PROMO_EN to accept 5-char promotion moves.
module uci_move_parser
  import uci_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int TIMEOUT_CYCLES   = INPUT_CLOCK_FREQ / 100
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       new_data_in,
  input  logic [7:0] data_byte_in,
  output logic       move_valid_out,
  output logic [5:0] from_sq_out,
  output logic [5:0] to_sq_out,
  output logic [2:0] promo_out,
  output logic       error_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  // Handshake: new_data_in is a fire-and-forget strobe. Every cycle it is
  // high one byte is consumed; there is no ready and no backpressure.

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      buf_q [5];
  logic [2:0]      len_q, len_d;
  logic            over_q, over_d;
  logic            store_en;
  logic [2:0]      store_pos;
  logic [TW-1:0]   tmo_q;
  logic            active;

  logic            res_good_q;
  logic [5:0]      res_from_q, res_to_q;
  logic [2:0]      res_promo_q;
  logic            latch_en;

  logic            emit_live, emit_latched, gap_err;
  logic            valid_d, error_d;
  logic [5:0]      load_from, load_to;
  logic [2:0]      load_promo;

  logic [5:0]      v_from, v_to;
  logic            v_from_ok, v_to_ok, v_len_ok, v_good;
  logic [2:0]      v_promo;

  uci_square_decode u_from_dec (
    .file_ch (buf_q[0]),
    .rank_ch (buf_q[1]),
    .sq      (v_from),
    .ok      (v_from_ok)
  );

  uci_square_decode u_to_dec (
    .file_ch (buf_q[2]),
    .rank_ch (buf_q[3]),
    .sq      (v_to),
    .ok      (v_to_ok)
  );

`ifdef UCI_PROMO_EN
  assign v_promo  = (len_q == 3'd5) ? promo_code(buf_q[4]) : PROMO_NONE;
  assign v_len_ok = (len_q == 3'd4) || ((len_q == 3'd5) && (v_promo != PROMO_NONE));
`else
  assign v_promo  = PROMO_NONE;
  assign v_len_ok = (len_q == 3'd4);
`endif

  assign v_good = !over_q && v_from_ok && v_to_ok && v_len_ok;
  assign active = (state_q != ST_KW) || (idx_q != 4'd0);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    over_d       = over_q;
    store_en     = 1'b0;
    store_pos    = len_q;
    latch_en     = 1'b0;
    emit_live    = 1'b0;
    emit_latched = 1'b0;
    gap_err      = 1'b0;

    if (new_data_in) begin
      if (data_byte_in != ASCII_CR) begin
        case (state_q)
          ST_KW: begin
            if (data_byte_in == ASCII_LF) begin
              idx_d = 4'd0;
            end else if (data_byte_in == ASCII_SPACE) begin
              state_d = (idx_q == KW_LEN) ? ST_GAP : ST_SKIP;
            end else if ((idx_q < KW_LEN) && (data_byte_in == kw_char(idx_q[2:0]))) begin
              idx_d = idx_q + 4'd1;
            end else begin
              state_d = ST_SKIP;
            end
          end
          ST_GAP: begin
            if (data_byte_in == ASCII_LF) begin
              gap_err = 1'b1;
              state_d = ST_KW;
              idx_d   = 4'd0;
            end else if (data_byte_in != ASCII_SPACE) begin
              state_d   = ST_MOVE;
              store_en  = 1'b1;
              store_pos = 3'd0;
              len_d     = 3'd1;
              over_d    = 1'b0;
            end
          end
          ST_MOVE: begin
            if (data_byte_in == ASCII_LF) begin
              emit_live = 1'b1;
              state_d   = ST_KW;
              idx_d     = 4'd0;
            end else if (data_byte_in == ASCII_SPACE) begin
              latch_en = 1'b1;
              state_d  = ST_TRAIL;
            end else if (len_q == 3'd5) begin
              over_d = 1'b1;
            end else begin
              store_en = 1'b1;
              len_d    = len_q + 3'd1;
            end
          end
          ST_TRAIL: begin
            if (data_byte_in == ASCII_LF) begin
              emit_latched = 1'b1;
              state_d      = ST_KW;
              idx_d        = 4'd0;
            end
          end
          ST_SKIP: begin
            if (data_byte_in == ASCII_LF) begin
              state_d = ST_KW;
              idx_d   = 4'd0;
            end
          end
          default: begin
            state_d = ST_KW;
            idx_d   = 4'd0;
          end
        endcase
      end
    end else if (active && (tmo_q == TMO_LAST)) begin
      state_d = ST_KW;
      idx_d   = 4'd0;
    end
  end

  always_comb begin
    valid_d    = (emit_live && v_good) || (emit_latched && res_good_q);
    error_d    = gap_err || (emit_live && !v_good) || (emit_latched && !res_good_q);
    load_from  = emit_live ? v_from  : res_from_q;
    load_to    = emit_live ? v_to    : res_to_q;
    load_promo = emit_live ? v_promo : res_promo_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_KW;
      idx_q          <= 4'd0;
      len_q          <= 3'd0;
      over_q         <= 1'b0;
      tmo_q          <= '0;
      res_good_q     <= 1'b0;
      res_from_q     <= 6'd0;
      res_to_q       <= 6'd0;
      res_promo_q    <= PROMO_NONE;
      move_valid_out <= 1'b0;
      error_out      <= 1'b0;
      from_sq_out    <= 6'd0;
      to_sq_out      <= 6'd0;
      promo_out      <= PROMO_NONE;
      for (int i = 0; i < 5; i++) buf_q[i] <= 8'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      over_q         <= over_d;
      move_valid_out <= valid_d;
      error_out      <= error_d;
      if (store_en) buf_q[store_pos] <= data_byte_in;
      if (latch_en) begin
        res_good_q  <= v_good;
        res_from_q  <= v_from;
        res_to_q    <= v_to;
        res_promo_q <= v_promo;
      end
      if (valid_d) begin
        from_sq_out <= load_from;
        to_sq_out   <= load_to;
        promo_out   <= load_promo;
      end
      // Counts idle cycles only while a line is in progress; saturates.
      if (new_data_in || !active) tmo_q <= '0;
      else if (tmo_q != TMO_MAX)  tmo_q <= tmo_q + TW'(1);
    end
  end

endmodule

// File: tb/tb_uci_move_parser.sv
// Scoreboard bench for uci_move_parser: directed UCI lines with
// hand-computed squares, checked by an independent negedge monitor.
module tb_uci_move_parser;

  localparam int TMO = 64;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       new_data_in;
  logic [7:0] data_byte_in;
  logic       move_valid_out;
  logic [5:0] from_sq_out;
  logic [5:0] to_sq_out;
  logic [2:0] promo_out;
  logic       error_out;

  uci_move_parser #(
    .INPUT_CLOCK_FREQ (100_000_000),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .new_data_in    (new_data_in),
    .data_byte_in   (data_byte_in),
    .move_valid_out (move_valid_out),
    .from_sq_out    (from_sq_out),
    .to_sq_out      (to_sq_out),
    .promo_out      (promo_out),
    .error_out      (error_out)
  );

  // clock / cycle counter
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // scoreboard state: {err, from[5:0], to[5:0], promo[2:0]}
  logic [15:0] exp_q[$];
  int          due_q[$];
  int          total = 0;
  int          bad = 0;
  int          req_cnt = 0;
  int          served = 0;
  bit          done = 1'b0;
  logic [14:0] held = '0;

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    new_data_in  = 1'b1;
    data_byte_in = b;
    @(posedge clk_in);
    #1;
    new_data_in  = 1'b0;
  endtask

  // Sends s; if exp_en, the last byte (the LF) carries the expectation.
  task automatic send_line(input string s, input bit exp_en, input bit exp_err,
                           input logic [5:0] f, input logic [5:0] t,
                           input logic [2:0] p);
    for (int i = 0; i < s.len(); i++) begin
      if (exp_en && (i == s.len() - 1)) begin
        exp_q.push_back({exp_err, f, t, p});
        due_q.push_back(cyc + 1);
      end
      send_byte(s[i]);
    end
  endtask

  task automatic hold_check();
    req_cnt++;
    idle(1);
  endtask

  // monitor
  always @(negedge clk_in) begin
    logic [15:0] e;
    logic [15:0] act;
    int          d;
    if (rst_in) begin
      held = '0;
    end else if (done) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL missing_strobes: outstanding=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else begin
      if (move_valid_out || error_out) begin
        total++;
        act = {error_out, from_sq_out, to_sq_out, promo_out};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: valid=%0b err=%0b outs=%h at cycle %0d",
                   move_valid_out, error_out, act, cyc);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          if (e[15]) e = {1'b1, held};
          else       held = e[14:0];
          if ((act !== e) || (move_valid_out == error_out) || (cyc != d)) begin
            bad++;
            $display("FAIL strobe: got %h valid=%0b cycle %0d, required %h cycle %0d",
                     act, move_valid_out, cyc, e, d);
          end
        end
      end else if (served < req_cnt) begin
        served++;
        total++;
        act = {1'b0, from_sq_out, to_sq_out, promo_out};
        if (act !== {1'b0, held}) begin
          bad++;
          $display("FAIL hold: outs=%h required=%h", act, {1'b0, held});
        end
      end
    end
  end

  // stimulus
  initial begin
    rst_in       = 1'b1;
    new_data_in  = 1'b0;
    data_byte_in = 8'd0;
    repeat (5) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    idle(2);
    hold_check();

    send_line("bestmove e2e4\n", 1, 0, 6'd12, 6'd28, 3'd0);
    idle(3);
    hold_check();

    send_line("bestmove g1f3 ponder b8c6\r\n", 1, 0, 6'd6, 6'd21, 3'd0);
    send_line("info depth 5\n", 0, 0, 0, 0, 0);
    send_line("readyok\n", 0, 0, 0, 0, 0);
    idle(3);
    hold_check();

`ifdef UCI_PROMO_EN
    send_line("bestmove a7a8q\n", 1, 0, 6'd48, 6'd56, 3'd4);
`else
    send_line("bestmove a7a8q\n", 1, 1, 6'd0, 6'd0, 3'd0);
`endif
    idle(2);
    hold_check();

    send_line("bestmove i9e4\n", 1, 1, 0, 0, 0);
    send_line("bestmove (none)\n", 1, 1, 0, 0, 0);
    send_line("bestmove \n", 1, 1, 0, 0, 0);
    idle(2);
    hold_check();

    send_line("bestmove  h8a1\n", 1, 0, 6'd63, 6'd0, 3'd0);
    send_line("bestmove", 0, 0, 0, 0, 0);
    idle(40);
    send_line(" c7c5\n", 1, 0, 6'd50, 6'd34, 3'd0);
    idle(2);
    hold_check();

    // fragment abandoned by timeout
    send_line("bestmo", 0, 0, 0, 0, 0);
    idle(TMO + 16);
    send_line("bestmove h2h1\n", 1, 0, 6'd15, 6'd7, 3'd0);
    idle(3);
    hold_check();

    // fragment abandoned by reset
    send_line("bestmo", 0, 0, 0, 0, 0);
    rst_in = 1'b1;
    idle(1);
    rst_in = 1'b0;
    send_line("ve h2h1\n", 0, 0, 0, 0, 0);
    idle(3);
    hold_check();

    // reset coinciding with the terminating LF suppresses the strobe
    send_line("bestmove e2e4", 0, 0, 0, 0, 0);
    new_data_in  = 1'b1;
    data_byte_in = 8'h0A;
    rst_in       = 1'b1;
    @(posedge clk_in);
    #1;
    new_data_in = 1'b0;
    rst_in      = 1'b0;
    idle(3);
    hold_check();

    send_line("bestmove d2d4\n", 1, 0, 6'd11, 6'd27, 3'd0);
    idle(3);
    hold_check();
    idle(2);
    done = 1'b1;
    idle(5);
  end

endmodule
